// File: rtl/fetch_queue_pkg.sv
// Shared types and constants for the instruction fetch queue.
// Entries carry the PC, instruction word and a misaligned-PC (AdEL) flag.
package fetch_pkg;

  localparam int          PC_W     = 32;
  localparam logic [31:0] NOP      = 32'h0000_0000;
  localparam logic [31:0] PC_RESET = 32'h0000_3000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        adel;
  } fq_entry_t;

  function automatic logic is_misaligned(input logic [31:0] pc);
    return (pc & 32'h0000_0003) != 32'h0;
  endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// Handshake bundle between IFU, fetch queue and decode, plus flush and occupancy.
// slave = queue side, master = the surrounding pipeline driving it.
interface fetch_queue_if #(parameter int DEPTH = 4);
  import fetch_pkg::*;

  logic                   in_valid;
  logic                   in_ready;
  logic [PC_W-1:0]        in_pc;
  logic [PC_W-1:0]        in_instr;
  logic                   out_valid;
  logic                   out_ready;
  logic [PC_W-1:0]        out_pc;
  logic [PC_W-1:0]        out_instr;
  logic                   out_adel;
  logic                   flush;
  logic [$clog2(DEPTH):0] count;

  modport slave (
    input  in_valid, in_pc, in_instr, out_ready, flush,
    output in_ready, out_valid, out_pc, out_instr, out_adel, count
  );

  modport master (
    output in_valid, in_pc, in_instr, out_ready, flush,
    input  in_ready, out_valid, out_pc, out_instr, out_adel, count
  );

endinterface

// File: rtl/fetch_queue_mem.sv
// DEPTH-entry register array: one write port, one asynchronous read port.
// Data is deliberately not reset; validity is tracked by the queue's count.
module fetch_queue_mem
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  fq_entry_t     wdata_i,
  input  logic [AW-1:0] raddr_i,
  output fq_entry_t     rdata_o
);

  fq_entry_t mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fetch_queue.sv
// In-order IFU->decode prefetch queue, DEPTH entries, 1-cycle push-to-head latency; refuses pushes when full or flushing.
// Optional FETCH_QUEUE_BYPASS_EN: empty queue forwards the input combinationally to the head.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic          Clk,
  input  logic          Reset,
  fetch_queue_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  fq_entry_t in_ent;
  fq_entry_t mem_rd;
  fq_entry_t head_ent;

  logic empty, full, byp;
  logic push, pop, store, deq, head_vld;

  assign in_ent = '{pc: bus.in_pc, instr: bus.in_instr, adel: is_misaligned(bus.in_pc)};
  assign empty  = (count_q == '0);
  assign full   = (count_q == CW'(DEPTH));

`ifdef FETCH_QUEUE_BYPASS_EN
  assign byp = empty & bus.in_valid & ~bus.flush;
`else
  assign byp = 1'b0;
`endif

  fetch_queue_mem #(.DEPTH(DEPTH)) u_mem (
    .clk     (Clk),
    .we_i    (store),
    .waddr_i (wr_ptr_q),
    .wdata_i (in_ent),
    .raddr_i (rd_ptr_q),
    .rdata_o (mem_rd)
  );

  always_comb begin
    head_vld = (~empty | byp) & ~bus.flush;
    head_ent = byp ? in_ent : mem_rd;

    bus.in_ready  = ~full & ~bus.flush;
    bus.out_valid = head_vld;
    bus.out_pc    = head_vld ? head_ent.pc    : '0;
    bus.out_instr = head_vld ? head_ent.instr : NOP;
    bus.out_adel  = head_vld & head_ent.adel;
    bus.count     = count_q;

    push  = bus.in_valid & bus.in_ready;
    pop   = head_vld & bus.out_ready;
    // A bypassed entry consumed this cycle never touches the array.
    store = push & ~(byp & bus.out_ready);
    deq   = pop & ~byp;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (bus.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (store) wr_ptr_d = wr_ptr_q + 1'b1;
      if (deq)   rd_ptr_d = rd_ptr_q + 1'b1;
      case ({store, deq})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: reset, fill/drain, wrap, flush, AdEL tagging, bypass (FETCH_QUEUE_BYPASS_EN).
module tb_fetch_queue;
  import fetch_pkg::*;

  logic Clk;
  logic Reset;
  int   n_chk;
  int   n_fail;

  fetch_queue_if #(.DEPTH(4)) bus ();

  fetch_queue #(.DEPTH(4)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic drive(input logic vld, input logic [31:0] pc);
    bus.in_valid = vld;
    bus.in_pc    = pc;
    bus.in_instr = 32'hC0DE_0000 | pc;
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    Reset  = 1'b0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    drive(1'b0, 32'h0);
    #12;
    check("rst_count", 32'(bus.count), 32'd0);
    check("rst_ovld", 32'(bus.out_valid), 32'd0);
    check("rst_oinstr", bus.out_instr, NOP);
    check("rst_opc", bus.out_pc, 32'h0);
    check("rst_iready", 32'(bus.in_ready), 32'd1);
    step();
    Reset = 1'b1;
    step();

    // T2 fill then drain
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, PC_RESET + 32'(4 * i));
      step();
    end
    drive(1'b0, 32'h0);
    #1;
    check("fill_count", 32'(bus.count), 32'd4);
    check("fill_iready", 32'(bus.in_ready), 32'd0);
    check("fill_head", bus.out_pc, 32'h3000);
    drive(1'b1, 32'h0000_3010);
    step();
    drive(1'b0, 32'h0);
    #1;
    check("full_refuse", 32'(bus.count), 32'd4);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("drain_vld", 32'(bus.out_valid), 32'd1);
      check("drain_pc", bus.out_pc, PC_RESET + 32'(4 * i));
      check("drain_instr", bus.out_instr, 32'hC0DE_0000 | (PC_RESET + 32'(4 * i)));
      step();
    end
    #1;
    check("drain_empty", 32'(bus.out_valid), 32'd0);
    check("drain_nop", bus.out_instr, NOP);
    check("drain_count", 32'(bus.count), 32'd0);

    // T3 push and pop together at count 2 across wrap
    bus.out_ready = 1'b0;
    drive(1'b1, 32'h0000_3100); step();
    drive(1'b1, 32'h0000_3104); step();
    bus.out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, 32'h0000_3108 + 32'(4 * k));
      #1;
      check("pp_pc", bus.out_pc, 32'h0000_3100 + 32'(4 * k));
      check("pp_count", 32'(bus.count), 32'd2);
      step();
    end
    drive(1'b0, 32'h0);
    #1;
    check("pp_count_end", 32'(bus.count), 32'd2);
    check("pp_head_end", bus.out_pc, 32'h0000_3128);
    step(); step();
    check("pp_drained", 32'(bus.count), 32'd0);

    // T4 flush with count 3 and a concurrent push
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h0000_3200 + 32'(4 * i));
      step();
    end
    drive(1'b1, 32'h0000_3300);
    bus.flush = 1'b1;
    #1;
    check("fl_iready", 32'(bus.in_ready), 32'd0);
    check("fl_ovld", 32'(bus.out_valid), 32'd0);
    step();
    bus.flush = 1'b0;
    drive(1'b0, 32'h0);
    #1;
    check("fl_count", 32'(bus.count), 32'd0);
    check("fl_ovld_after", 32'(bus.out_valid), 32'd0);
    drive(1'b1, 32'h0000_3400);
    step();
    drive(1'b0, 32'h0);
    #1;
    check("fl_next_count", 32'(bus.count), 32'd1);
    check("fl_next_head", bus.out_pc, 32'h0000_3400);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;

    // T5 misaligned PC tagging
    drive(1'b1, 32'h0000_3002); step();
    drive(1'b1, 32'h0000_3404); step();
    drive(1'b0, 32'h0);
    #1;
    check("adel_set", 32'(bus.out_adel), 32'd1);
    check("adel_pc", bus.out_pc, 32'h0000_3002);
    bus.out_ready = 1'b1;
    step();
    check("adel_clr", 32'(bus.out_adel), 32'd0);
    check("adel_next_pc", bus.out_pc, 32'h0000_3404);
    step();
    check("adel_empty", 32'(bus.count), 32'd0);

    // T6 empty queue with a push and a ready consumer
    drive(1'b1, 32'h0000_3010);
    #1;
`ifdef FETCH_QUEUE_BYPASS_EN
    check("byp_ovld", 32'(bus.out_valid), 32'd1);
    check("byp_pc", bus.out_pc, 32'h0000_3010);
    step();
    drive(1'b0, 32'h0);
    #1;
    check("byp_count", 32'(bus.count), 32'd0);
    check("byp_empty", 32'(bus.out_valid), 32'd0);
`else
    check("nobyp_ovld", 32'(bus.out_valid), 32'd0);
    step();
    drive(1'b0, 32'h0);
    #1;
    check("nobyp_count", 32'(bus.count), 32'd1);
    check("nobyp_pc", bus.out_pc, 32'h0000_3010);
    step();
    check("nobyp_drain", 32'(bus.count), 32'd0);
`endif

    // T1 asynchronous reset mid-stream
    bus.out_ready = 1'b0;
    drive(1'b1, 32'h0000_3500); step();
    drive(1'b1, 32'h0000_3504); step();
    drive(1'b0, 32'h0);
    #1;
    check("pre_rst_count", 32'(bus.count), 32'd2);
    Reset = 1'b0;
    #1;
    check("arst_count", 32'(bus.count), 32'd0);
    check("arst_ovld", 32'(bus.out_valid), 32'd0);
    check("arst_oinstr", bus.out_instr, NOP);
    check("arst_iready", 32'(bus.in_ready), 32'd1);
    step();
    Reset = 1'b1;
    step();
    check("post_rst_empty", 32'(bus.out_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
